// File: rtl/r32i_mem_pkg.sv
// Shared types and helpers for the shared-memory-port arbiter.
package r32i_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arbState_t;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Port index width; a single-bit index is kept even for one port so vectors never collapse.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_pick_r32i.sv
// Combinational winner selection: lowest index (fixed) or first valid after LastGrant (round-robin).
module arb_pick_r32i
  import r32i_mem_pkg::*;
#(
  parameter int NumPorts     = 2,
  parameter int PriorityMode = PRIO_FIXED,
  localparam int IdxW        = idxWidth(NumPorts)
) (
  input  logic [NumPorts-1:0] ReqValid,
  input  logic [IdxW-1:0]     LastGrant,
  output logic                AnyValid,
  output logic [IdxW-1:0]     WinnerIdx,
  output logic [NumPorts-1:0] WinnerOneHot
);

  always_comb begin
    int start;
    AnyValid     = 1'b0;
    WinnerIdx    = '0;
    WinnerOneHot = '0;
    start        = (PriorityMode == PRIO_RR) ? ((int'(LastGrant) + 1) % NumPorts) : 0;
    // Wrapped region first, then the region at/after start overrides; descending scan keeps the lowest.
    for (int k = NumPorts - 1; k >= 0; k--) begin
      if (ReqValid[k] && (k < start)) begin
        AnyValid        = 1'b1;
        WinnerIdx       = IdxW'(k);
        WinnerOneHot    = '0;
        WinnerOneHot[k] = 1'b1;
      end
    end
    for (int k = NumPorts - 1; k >= 0; k--) begin
      if (ReqValid[k] && (k >= start)) begin
        AnyValid        = 1'b1;
        WinnerIdx       = IdxW'(k);
        WinnerOneHot    = '0;
        WinnerOneHot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_r32i.sv
// NumPorts-way arbiter onto a single variable-latency RAM port, with a wait-state watchdog.
//   state | meaning
//   IDLE  | pick a winner, strobe its ReqReady, latch its request
//   WAIT  | MemReq asserted with latched payload until MemAck or timeout
//   RESP  | one-cycle RespValid to the owner, then back to IDLE
module mem_arbiter_r32i
  import r32i_mem_pkg::*;
#(
  parameter int dataW         = 32,
  parameter int RAMAddrSize   = 32,
  parameter int NumPorts      = 2,
  parameter int PriorityMode  = PRIO_FIXED,
  parameter int TimeoutCycles = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NumPorts-1:0]             ReqValid,
  input  logic [NumPorts-1:0]             ReqWrite,
  input  logic [NumPorts*RAMAddrSize-1:0] ReqAddr,
  input  logic [NumPorts*dataW-1:0]       ReqData,
  output logic [NumPorts-1:0]             ReqReady,
  output logic [NumPorts-1:0]             RespValid,
  output logic [dataW-1:0]                RespData,
  output logic                            RespError,
  output logic                            MemReq,
  output logic                            MemWrite,
  output logic [RAMAddrSize-1:0]          MemAddr,
  output logic [dataW-1:0]                MemDataOut,
  input  logic                            MemAck,
  input  logic [dataW-1:0]                MemDataIn,
  output logic                            Busy
);

  localparam int IdxW = idxWidth(NumPorts);
  localparam int CntW = $clog2(TimeoutCycles + 1);

  arbState_t              state, nextState;
  logic [IdxW-1:0]        lastGrant, owner;
  logic                   latWrite;
  logic [RAMAddrSize-1:0] latAddr;
  logic [dataW-1:0]       latData;
  logic [CntW-1:0]        waitCount;
  logic [dataW-1:0]       respData;
  logic                   respError;

  logic                   anyValid;
  logic [IdxW-1:0]        winnerIdx;
  logic [NumPorts-1:0]    winnerOneHot;
  logic                   selWrite;
  logic [RAMAddrSize-1:0] selAddr;
  logic [dataW-1:0]       selData;
  logic                   timeoutHit;

  arb_pick_r32i #(
    .NumPorts    (NumPorts),
    .PriorityMode(PriorityMode)
  ) uPick (
    .ReqValid    (ReqValid),
    .LastGrant   (lastGrant),
    .AnyValid    (anyValid),
    .WinnerIdx   (winnerIdx),
    .WinnerOneHot(winnerOneHot)
  );

  always_comb begin
    selWrite = 1'b0;
    selAddr  = '0;
    selData  = '0;
    for (int k = 0; k < NumPorts; k++) begin
      if (winnerOneHot[k]) begin
        selWrite = ReqWrite[k];
        selAddr  = ReqAddr[k*RAMAddrSize +: RAMAddrSize];
        selData  = ReqData[k*dataW +: dataW];
      end
    end
  end

  assign timeoutHit = (waitCount == CntW'(TimeoutCycles));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyValid) nextState = WAIT;
      WAIT:    if (MemAck || timeoutHit) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lastGrant <= IdxW'(NumPorts - 1);
      owner     <= '0;
      latWrite  <= 1'b0;
      latAddr   <= '0;
      latData   <= '0;
      waitCount <= '0;
      respData  <= '0;
      respError <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          waitCount <= '0;
          if (anyValid) begin
            owner     <= winnerIdx;
            lastGrant <= winnerIdx;
            latWrite  <= selWrite;
            latAddr   <= selAddr;
            latData   <= selData;
          end
        end
        WAIT: begin
          // An ack on the expiry cycle still completes the access cleanly.
          if (MemAck) begin
            respData  <= latWrite ? '0 : MemDataIn;
            respError <= 1'b0;
          end else if (timeoutHit) begin
            respData  <= '0;
            respError <= 1'b1;
          end else begin
            waitCount <= waitCount + 1'b1;
          end
        end
        default: waitCount <= '0;
      endcase
    end
  end

  always_comb begin
    ReqReady  = '0;
    RespValid = '0;
    if (state == IDLE && !reset) ReqReady = winnerOneHot;
    for (int k = 0; k < NumPorts; k++) begin
      if (state == RESP && owner == IdxW'(k)) RespValid[k] = 1'b1;
    end
    MemReq     = (state == WAIT) && !timeoutHit;
    MemWrite   = MemReq && latWrite;
    MemAddr    = latAddr;
    MemDataOut = latData;
    RespData   = respData;
    RespError  = respError;
    Busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter_r32i.sv
// Directed bench: a 2-port fixed-priority instance and a 4-port round-robin instance, both with a 4-cycle timeout.
module tb_mem_arbiter_r32i;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]   fValid = '0, fWrite = '0, fReady, fRespValid;
  logic [63:0]  fAddr = '0, fData = '0;
  logic [31:0]  fRespData, fMemAddr, fMemDout, fMemDin = '0;
  logic         fRespErr, fMemReq, fMemWrite, fAck = 1'b0, fBusy;

  logic [3:0]   rValid = '0, rWrite = '0, rReady, rRespValid;
  logic [127:0] rAddr = '0, rData = '0;
  logic [31:0]  rRespData, rMemAddr, rMemDout, rMemDin = '0;
  logic         rRespErr, rMemReq, rMemWrite, rAck = 1'b0, rBusy;

  int checks = 0;
  int errors = 0;

  mem_arbiter_r32i #(.NumPorts(2), .PriorityMode(0), .TimeoutCycles(4)) dutF (
    .clock(clock), .reset(reset),
    .ReqValid(fValid), .ReqWrite(fWrite), .ReqAddr(fAddr), .ReqData(fData),
    .ReqReady(fReady), .RespValid(fRespValid), .RespData(fRespData), .RespError(fRespErr),
    .MemReq(fMemReq), .MemWrite(fMemWrite), .MemAddr(fMemAddr), .MemDataOut(fMemDout),
    .MemAck(fAck), .MemDataIn(fMemDin), .Busy(fBusy)
  );

  mem_arbiter_r32i #(.NumPorts(4), .PriorityMode(1), .TimeoutCycles(4)) dutR (
    .clock(clock), .reset(reset),
    .ReqValid(rValid), .ReqWrite(rWrite), .ReqAddr(rAddr), .ReqData(rData),
    .ReqReady(rReady), .RespValid(rRespValid), .RespData(rRespData), .RespError(rRespErr),
    .MemReq(rMemReq), .MemWrite(rMemWrite), .MemAddr(rMemAddr), .MemDataOut(rMemDout),
    .MemAck(rAck), .MemDataIn(rMemDin), .Busy(rBusy)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset dominance
    fValid = 2'b11;
    rValid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      checkEq("rstFReady", fReady, 0);
      checkEq("rstRReady", rReady, 0);
      checkEq("rstMemReq", {fMemReq, rMemReq}, 0);
      checkEq("rstRespValid", {fRespValid, rRespValid}, 0);
      checkEq("rstBusy", {fBusy, rBusy}, 0);
    end
    checkEq("rstRespData", fRespData, 0);
    checkEq("rstMemAddr", fMemAddr, 0);
    checkEq("rstMemDout", fMemDout, 0);
    checkEq("rstMemWrite", fMemWrite, 0);
    checkEq("rstRespErr", fRespErr, 0);
    reset = 1'b0;
    #1;
    checkEq("firstFReady", fReady, 2'b01);
    checkEq("firstRReady", rReady, 4'b0001);
    fValid = '0;
    rValid = '0;

    // single read on port 1, ack after 3 wait cycles
    step();
    fValid = 2'b10;
    fWrite = 2'b00;
    fAddr  = {32'h0000_0040, 32'h0};
    #1;
    checkEq("rdReady", fReady, 2'b10);
    step();
    fValid = '0;
    #1;
    checkEq("rdMemReq1", fMemReq, 1);
    checkEq("rdMemAddr", fMemAddr, 32'h40);
    checkEq("rdMemWrite", fMemWrite, 0);
    checkEq("rdBusy", fBusy, 1);
    checkEq("rdReadyWait", fReady, 0);
    step();
    #1;
    checkEq("rdMemReq2", fMemReq, 1);
    step();
    fAck   = 1'b1;
    fMemDin = 32'hDEAD_BEEF;
    #1;
    checkEq("rdMemReq3", fMemReq, 1);
    step();
    fAck = 1'b0;
    #1;
    checkEq("rdRespValid", fRespValid, 2'b10);
    checkEq("rdRespData", fRespData, 32'hDEAD_BEEF);
    checkEq("rdRespErr", fRespErr, 0);
    checkEq("rdMemReqResp", fMemReq, 0);
    step();
    #1;
    checkEq("rdRespDone", fRespValid, 0);
    checkEq("rdIdleBusy", fBusy, 0);
    checkEq("rdRespHold", fRespData, 32'hDEAD_BEEF);

    // fixed priority with both ports continuously valid
    fValid = 2'b11;
    fAddr  = {32'h0000_0200, 32'h0000_0100};
    for (int n = 0; n < 3; n++) begin
      #1;
      checkEq("fixReady", fReady, 2'b01);
      step();
      fAck    = 1'b1;
      fMemDin = 32'h1111_0000 + n;
      #1;
      checkEq("fixMemAddr", fMemAddr, 32'h100);
      checkEq("fixReadyWait", fReady, 0);
      step();
      fAck = 1'b0;
      #1;
      checkEq("fixRespValid", fRespValid, 2'b01);
      checkEq("fixRespData", fRespData, 32'h1111_0000 + n);
      checkEq("fixReadyResp", fReady, 0);
      step();
    end
    fValid = '0;

    // round-robin, four writers continuously valid
    rValid  = 4'hF;
    rWrite  = 4'hF;
    rMemDin = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      rAddr[i*32 +: 32] = 32'h1000 + 4 * i;
      rData[i*32 +: 32] = 32'hA0 + i;
    end
    for (int n = 0; n < 5; n++) begin
      int exp;
      exp = n % 4;
      #1;
      checkEq("rrReady", rReady, 64'(1) << exp);
      step();
      rAck = 1'b1;
      #1;
      checkEq("rrMemWrite", rMemWrite, 1);
      checkEq("rrMemAddr", rMemAddr, 32'h1000 + 4 * exp);
      checkEq("rrMemDout", rMemDout, 32'hA0 + exp);
      step();
      rAck = 1'b0;
      #1;
      checkEq("rrRespValid", rRespValid, 64'(1) << exp);
      checkEq("rrRespData", rRespData, 0);
      step();
    end
    rValid = '0;

    // ack while idle is ignored
    fAck    = 1'b1;
    fMemDin = 32'h55;
    step();
    fAck = 1'b0;
    #1;
    checkEq("idleAckBusy", fBusy, 0);
    checkEq("idleAckResp", fRespValid, 0);

    // timeout with no ack
    fValid = 2'b01;
    fWrite = 2'b00;
    fAddr  = {32'h0, 32'h0000_0300};
    #1;
    checkEq("toReady", fReady, 2'b01);
    step();
    fValid = '0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checkEq("toMemReq", fMemReq, 1);
      step();
    end
    #1;
    checkEq("toMemReqLow", fMemReq, 0);
    checkEq("toBusy", fBusy, 1);
    checkEq("toNoRespYet", fRespValid, 0);
    step();
    #1;
    checkEq("toRespValid", fRespValid, 2'b01);
    checkEq("toRespErr", fRespErr, 1);
    checkEq("toRespData", fRespData, 0);
    step();
    #1;
    checkEq("toIdle", fBusy, 0);

    // ack on the expiry cycle wins
    fValid = 2'b01;
    #1;
    checkEq("toAckReady", fReady, 2'b01);
    step();
    fValid = '0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checkEq("toAckMemReq", fMemReq, 1);
      step();
    end
    fAck    = 1'b1;
    fMemDin = 32'hCAFE_F00D;
    #1;
    checkEq("toAckMemReqLow", fMemReq, 0);
    step();
    fAck = 1'b0;
    #1;
    checkEq("toAckRespValid", fRespValid, 2'b01);
    checkEq("toAckRespErr", fRespErr, 0);
    checkEq("toAckRespData", fRespData, 32'hCAFE_F00D);
    step();

    // reset during WAIT abandons the write
    fValid = 2'b10;
    fWrite = 2'b10;
    fAddr  = {32'h0000_0080, 32'h0};
    fData  = {32'h1234_5678, 32'h0};
    #1;
    checkEq("rwReady", fReady, 2'b10);
    step();
    fValid = '0;
    #1;
    checkEq("rwMemReq", fMemReq, 1);
    checkEq("rwMemWrite", fMemWrite, 1);
    checkEq("rwMemDout", fMemDout, 32'h1234_5678);
    reset = 1'b1;
    step();
    #1;
    checkEq("rwMemReqRst", fMemReq, 0);
    checkEq("rwBusyRst", fBusy, 0);
    checkEq("rwRespRst", fRespValid, 0);
    checkEq("rwAddrRst", fMemAddr, 0);
    checkEq("rwDataRst", fRespData, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      checkEq("rwNoResp", fRespValid, 0);
      checkEq("rwNoMemReq", fMemReq, 0);
    end

    // new request after reset, minimum latency
    fValid = 2'b10;
    fWrite = 2'b00;
    fAddr  = {32'h0000_0084, 32'h0};
    #1;
    checkEq("newReady", fReady, 2'b10);
    step();
    fValid  = '0;
    fAck    = 1'b1;
    fMemDin = 32'h0BAD_CAFE;
    #1;
    checkEq("newMemReq", fMemReq, 1);
    checkEq("newMemAddr", fMemAddr, 32'h84);
    step();
    fAck = 1'b0;
    #1;
    checkEq("newRespValid", fRespValid, 2'b10);
    checkEq("newRespData", fRespData, 32'h0BAD_CAFE);
    checkEq("newRespErr", fRespErr, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_r32i.md
Name: mem_arbiter_r32i

Overview:
Parametrised multi-requester arbiter for the single shared data/instruction memory port. It generalises the two-way fetch/data address steering to NumPorts requesters and supports fixed-priority or round-robin selection. Each request uses a valid/ready handshake toward a variable-latency RAM with a MemReq/MemAck handshake, plus a timeout watchdog. It sits between the fetch unit, load/store path and any future DMA masters on one side and the RAM on the other.

Parameters:
dataW, 32, data word width
RAMAddrSize, 32, address width
NumPorts, 2, number of requesters (2..8)
PriorityMode, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
TimeoutCycles, 255, cycles in WAIT without MemAck before an error response (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ReqValid  in  NumPorts  per-port request valid
ReqWrite  in  NumPorts  per-port 1 = write, 0 = read
ReqAddr  in  NumPorts*RAMAddrSize  packed addresses, port i at [i*RAMAddrSize +: RAMAddrSize]
ReqData  in  NumPorts*dataW  packed write data
ReqReady  out  NumPorts  one-hot accept strobe
RespValid  out  NumPorts  one-hot single-cycle response strobe
RespData  out  dataW  shared read data, valid with RespValid
RespError  out  1  qualifies RespValid: timeout occurred
MemReq  out  1  memory request, held until MemAck
MemWrite  out  1  memory write enable
MemAddr  out  RAMAddrSize  memory address
MemDataOut  out  dataW  memory write data
MemAck  in  1  memory completion, single-cycle
MemDataIn  in  dataW  memory read data, valid with MemAck
Busy  out  1  high in every state except IDLE

Behaviour:
- Clock is clock. Reset is synchronous and active-high. One clock domain.
- States: IDLE, WAIT, RESP. At most one transaction is outstanding.
- Reset (at the clock edge): state = IDLE, LastGrant = NumPorts-1, timeout counter = 0. All outputs read 0 after the edge, including RespData and the Mem* outputs.
- Reset mid-transaction abandons the transaction. No RespValid is issued, and MemReq is low after the reset edge.
- IDLE: the winner is computed combinationally from ReqValid.
  - Fixed mode: the lowest set index wins.
  - RR mode: search starts at LastGrant+1 and wraps modulo NumPorts.
- In IDLE, ReqReady[winner] is 1 in the same cycle. ReqReady is 0 in all other states. The handshake completes when ReqValid[i] and ReqReady[i] are both high.
- On handshake: latch owner index, ReqWrite, ReqAddr and ReqData. Update LastGrant to the owner (in both modes). Go to WAIT.
- WAIT: MemReq = 1, and MemWrite/MemAddr/MemDataOut are driven from the latched values, held stable until MemAck. The counter increments each WAIT cycle.
- MemAck in WAIT: latch MemDataIn into RespData (0 for writes), clear RespError, go to RESP.
- Timeout: the counter reaches TimeoutCycles without MemAck. Then RespData = 0, RespError = 1, go to RESP, and MemReq drops.
- MemAck in the same cycle as timeout expiry: the ack wins, with no error.
- RESP: RespValid[owner] = 1 for exactly one cycle, with RespData/RespError stable. Then go to IDLE, counter = 0. RespData holds its value until the next response.
- Latency: accept at cycle 0, MemReq from cycle 1, MemAck at cycle k gives RespValid at cycle k+1. Minimum request-to-response latency is 2 cycles. Maximum throughput is one transaction per 3 cycles.
- MemAck outside WAIT is ignored.
- Requesters hold ReqValid and payload until ReqReady. Dropping ReqValid before acceptance is legal and leaves no side effect.
- Out-of-range ports are impossible: the winner is always less than NumPorts. With no ReqValid set, the block stays in IDLE.

Decomposition:
- Package r32i_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP)
  - constants PRIO_FIXED = 0, PRIO_RR = 1
  - a localparam function for the index width, clog2(NumPorts) with a minimum of 1.
- One combinational sub-module, arb_pick_r32i (parameters NumPorts, PriorityMode):
  - inputs: ReqValid, LastGrant
  - outputs: AnyValid, WinnerIdx, WinnerOneHot.
- The FSM, latches, counter and Mem* drive stay in the top module.

Test Plan:
1. Reset dominance: hold reset high for 3 cycles while ReqValid=2'b11 → ReqReady=0, MemReq=0, RespValid=0, Busy=0 throughout. In the first cycle after reset, port 0 wins in both modes.
2. Single read: port 1 reads 0x00000040, memory acks after 3 WAIT cycles with 0xDEADBEEF → ReqReady[1] at cycle 0, MemReq cycles 1-3 with MemAddr=0x40, RespValid=2'b10 at cycle 4 with RespData=0xDEADBEEF, RespError=0.
3. Fixed priority: ReqValid=2'b11 held continuously, ack after 1 cycle → every grant goes to port 0, and port 1 is never ready.
4. Round-robin, NumPorts=4: all four valid continuously → grant order 0,1,2,3,0. Write transactions give RespData=0.
5. Timeout, TimeoutCycles=4, no ack → RespValid at cycle 6 with RespError=1, RespData=0, MemReq low from cycle 5. An ack injected on the expiry cycle instead yields RespError=0.
6. Reset asserted during WAIT → no RespValid is issued and MemReq=0 after the edge. A new request is accepted normally afterwards.
